// File: rtl/bank_rd_seq_pkg.sv
// Shared definitions for the four-bank read sequencer: bank geometry, FIFO sizing,
// sequencer state encoding and bank-select helpers.
package bank_rd_seq_pkg;

  localparam int NUM_BANKS  = 4;
  localparam int BANK_SEL_W = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = 2;
  localparam int CNT_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [BANK_SEL_W-1:0] sel);
    logic [NUM_BANKS-1:0] one;
    one = NUM_BANKS'(1);
    return one << sel;
  endfunction

  function automatic logic [BANK_SEL_W-1:0] onehot_to_sel(input logic [NUM_BANKS-1:0] oh);
    logic [BANK_SEL_W-1:0] s;
    s = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (oh[i]) s = BANK_SEL_W'(i);
    end
    return s;
  endfunction

endpackage

// File: rtl/bank_rd_fifo.sv
// Four-entry output FIFO for returned bank words; supports push and pop in the
// same cycle and clears its storage on reset so the head reads zero.
module bank_rd_fifo
  import bank_rd_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CNT_W-1:0]      count_o
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/bank_rd_seq.sv
// Read sequencer: turns (addr, len) requests into one-hot bank reads, steers the
// downstream bank mux one cycle later and buffers returned words in a small FIFO.
module bank_rd_seq
  import bank_rd_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [LEN_WIDTH-1:0]  req_len_i,
  output logic [NUM_BANKS-1:0]  bank_rd_en_o,
  output logic [ADDR_WIDTH-3:0] bank_rd_addr_o,
  output logic [BANK_SEL_W-1:0] mux_sel_o,
  input  logic [DATA_WIDTH-1:0] mux_out_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  done_o
);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cur_addr_q;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic [NUM_BANKS-1:0]  rd_en_q;
  logic [ADDR_WIDTH-3:0] rd_addr_q;
  logic [BANK_SEL_W-1:0] mux_sel_q;
  logic                  ret_q;
  logic                  done_q;

  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_d;
  logic [CNT_W-1:0]      occ_d;
  logic                  push;
  logic                  pop;
  logic                  issue_d;

  assign push = ret_q;
  assign pop  = out_valid_o && out_ready_i;

  // Issue only if the word about to be launched still fits alongside the
  // post-edge occupancy and the read already on the bank address bus.
  always_comb begin
    count_d = count;
    if (push && !pop)      count_d = count + CNT_W'(1);
    else if (!push && pop) count_d = count - CNT_W'(1);
    occ_d   = count_d + CNT_W'(|rd_en_q);
    issue_d = (state_q == ST_RUN) && (occ_d < CNT_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      rd_en_q     <= '0;
      rd_addr_q   <= '0;
      mux_sel_q   <= '0;
      ret_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      rd_en_q <= '0;
      ret_q   <= |rd_en_q;
      if (|rd_en_q) mux_sel_q <= onehot_to_sel(rd_en_q);
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            if (req_len_i == '0) begin
              done_q <= 1'b1;
            end else begin
              cur_addr_q  <= req_addr_i;
              remaining_q <= req_len_i;
              state_q     <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (issue_d) begin
            rd_en_q     <= bank_onehot(cur_addr_q[BANK_SEL_W-1:0]);
            rd_addr_q   <= cur_addr_q[ADDR_WIDTH-1:BANK_SEL_W];
            cur_addr_q  <= cur_addr_q + ADDR_WIDTH'(1);
            remaining_q <= remaining_q - LEN_WIDTH'(1);
            if (remaining_q == LEN_WIDTH'(1)) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (rd_en_q == '0 && !ret_q && count == '0) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  bank_rd_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .push_i     (push),
    .push_data_i(mux_out_i),
    .pop_i      (pop),
    .data_o     (out_data_o),
    .count_o    (count)
  );

  assign req_ready_o    = (state_q == ST_IDLE);
  assign bank_rd_en_o   = rd_en_q;
  assign bank_rd_addr_o = rd_addr_q;
  assign mux_sel_o      = mux_sel_q;
  assign out_valid_o    = (count != '0);
  assign done_o         = done_q;

endmodule
